// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the pipeline WB stage
//   and the multi-cycle multiply/divide unit. MD results wait in a small FIFO.
//   The WB stage has priority until the FIFO head has been denied MAX_WAIT
//   times. After that, one MD write is forced through and the WB stage is
//   stalled for that cycle.
//
//   Optional build macro: RF_WAW_SQUASH_EN. When it is defined, a granted WB
//   write invalidates any buffered MD result with the same destination.
//   Invalid entries are then drained without writing.
//
// Ports
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   WB_RegWrite         WB stage write request
//   WB_MUX8_out         WB stage destination register
//   WB_Write_data       WB stage write data
//   MD_valid            MD result offered
//   MD_dest             MD destination register
//   MD_result           MD result data
//   MD_ready            FIFO can accept an MD result
//   Pipe_stall          WB stage must hold its registers this cycle
//   RF_RegWrite         register-file write enable
//   RF_Write_register   register-file write address
//   RF_Write_data       register-file write data
//   MD_pending          FIFO holds at least one result
module rf_write_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned rwidth   = 5,
    parameter int unsigned word     = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WB_RegWrite,
    input  logic [rwidth-1:0] WB_MUX8_out,
    input  logic [word-1:0]   WB_Write_data,
    input  logic              MD_valid,
    input  logic [rwidth-1:0] MD_dest,
    input  logic [word-1:0]   MD_result,
    output logic              MD_ready,
    output logic              Pipe_stall,
    output logic              RF_RegWrite,
    output logic [rwidth-1:0] RF_Write_register,
    output logic [word-1:0]   RF_Write_data,
    output logic              MD_pending
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [WW-1:0]     wait_cnt;
    logic [WW-1:0]     wait_nxt;

    logic [rwidth-1:0] fifo_dest [DEPTH];
    logic [word-1:0]   fifo_data [DEPTH];

    logic pipe_req;
    logic push;
    logic pop;
    logic grant_pipe;
    logic stall;
    logic head_valid;

`ifdef RF_WAW_SQUASH_EN
    logic [DEPTH-1:0]  fifo_vld;
    assign head_valid = fifo_vld[rd_ptr];
`else
    assign head_valid = 1'b1;
`endif

    assign pipe_req = WB_RegWrite & (WB_MUX8_out != '0);
    // MD_ready depends only on the registered count. A pop in the same cycle
    // therefore does not open a slot until the next cycle.
    assign MD_ready   = ~Reset & (count != CW'(DEPTH));
    // A handshake to $0 completes but stores nothing.
    assign push       = MD_valid & MD_ready & (MD_dest != '0);
    assign MD_pending = (count != '0);

    always_comb begin
        pop        = 1'b0;
        grant_pipe = 1'b1;
        stall      = 1'b0;
        wait_nxt   = wait_cnt;
        case (state)
            PEND: begin
                if (pipe_req) begin
                    if (wait_cnt != WW'(MAX_WAIT))
                        wait_nxt = wait_cnt + 1'b1;
                end else begin
                    grant_pipe = 1'b0;
                    pop        = 1'b1;
                    if (head_valid)
                        wait_nxt = '0;
                end
            end
            FORCE: begin
                grant_pipe = 1'b0;
                pop        = 1'b1;
                stall      = pipe_req;
                if (head_valid)
                    wait_nxt = '0;
            end
            default: ;
        endcase
        count_nxt = count + CW'(push) - CW'(pop);
        if (count_nxt == '0)
            wait_nxt = '0;
    end

    // While Reset is high, write enable and stall are gated off even though
    // IDLE would otherwise pass the WB request straight through.
    assign RF_RegWrite       = ~Reset & (grant_pipe ? pipe_req : head_valid);
    assign RF_Write_register = grant_pipe ? WB_MUX8_out   : fifo_dest[rd_ptr];
    assign RF_Write_data     = grant_pipe ? WB_Write_data : fifo_data[rd_ptr];
    assign Pipe_stall        = ~Reset & stall;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
`ifdef RF_WAW_SQUASH_EN
            fifo_vld <= '0;
`endif
        end else begin
            count    <= count_nxt;
            wait_cnt <= wait_nxt;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
`ifdef RF_WAW_SQUASH_EN
            if (grant_pipe && pipe_req) begin
                for (int unsigned i = 0; i < DEPTH; i++)
                    if (fifo_dest[i] == WB_MUX8_out)
                        fifo_vld[i] <= 1'b0;
            end
`endif
            if (push) begin
                fifo_dest[wr_ptr] <= MD_dest;
                fifo_data[wr_ptr] <= MD_result;
`ifdef RF_WAW_SQUASH_EN
                fifo_vld[wr_ptr]  <= 1'b1;
`endif
                wr_ptr <= wr_ptr + 1'b1;
            end
            // The next state is chosen from the post-update count and wait
            // values, so the outputs can be decoded from state alone.
            if (count_nxt == '0)
                state <= IDLE;
            else if (wait_nxt == WW'(MAX_WAIT))
                state <= FORCE;
            else
                state <= PEND;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXW  = 3;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        WB_RegWrite = 1'b0;
    logic [4:0]  WB_MUX8_out = '0;
    logic [31:0] WB_Write_data = '0;
    logic        MD_valid = 1'b0;
    logic [4:0]  MD_dest = '0;
    logic [31:0] MD_result = '0;
    logic        MD_ready;
    logic        Pipe_stall;
    logic        RF_RegWrite;
    logic [4:0]  RF_Write_register;
    logic [31:0] RF_Write_data;
    logic        MD_pending;

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAXW), .rwidth(5), .word(32)) dut (
        .Clock(Clock), .Reset(Reset),
        .WB_RegWrite(WB_RegWrite), .WB_MUX8_out(WB_MUX8_out), .WB_Write_data(WB_Write_data),
        .MD_valid(MD_valid), .MD_dest(MD_dest), .MD_result(MD_result),
        .MD_ready(MD_ready), .Pipe_stall(Pipe_stall), .RF_RegWrite(RF_RegWrite),
        .RF_Write_register(RF_Write_register), .RF_Write_data(RF_Write_data),
        .MD_pending(MD_pending)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: an ordered list of buffered results plus a denial count.
    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        vld;
    } ent_t;

    ent_t q[$];
    int   mwait = 0;
    logic m_hold = 1'b0;

    always begin : compare
        logic gp, preq, e_we, e_stall, e_ready;
        logic [4:0] e_reg;
        logic [31:0] e_data;
        int n;
        ent_t h;
        @(negedge Clock);
        gp = 1'b1; preq = 1'b0; e_ready = 1'b0; e_stall = 1'b0;
        if (Reset) begin
            q.delete(); mwait = 0;
            chk("rst_we", 32'(RF_RegWrite), 0);
            chk("rst_stall", 32'(Pipe_stall), 0);
            chk("rst_ready", 32'(MD_ready), 0);
            chk("rst_pending", 32'(MD_pending), 0);
        end else begin
            n    = q.size();
            preq = WB_RegWrite && (WB_MUX8_out != 0);
            if (n == 0)           gp = 1'b1;
            else if (mwait >= MAXW) gp = 1'b0;
            else                  gp = preq;
            if (gp) begin
                e_we = preq; e_reg = WB_MUX8_out; e_data = WB_Write_data;
            end else begin
                e_we = q[0].vld; e_reg = q[0].dest; e_data = q[0].data;
            end
            e_stall = (n != 0) && (mwait >= MAXW) && preq;
            e_ready = (n < DEPTH);
            chk("rf_we", 32'(RF_RegWrite), 32'(e_we));
            if (e_we) begin
                chk("rf_reg", 32'(RF_Write_register), 32'(e_reg));
                chk("rf_data", RF_Write_data, e_data);
            end
            chk("stall", 32'(Pipe_stall), 32'(e_stall));
            chk("ready", 32'(MD_ready), 32'(e_ready));
            chk("pending", 32'(MD_pending), 32'(n != 0));
        end
        @(posedge Clock);
        if (Reset) begin
            q.delete(); mwait = 0; m_hold = 1'b0;
        end else begin
            if (gp && q.size() != 0)
                mwait = (mwait + 1 > MAXW) ? MAXW : mwait + 1;
`ifdef RF_WAW_SQUASH_EN
            if (gp && preq)
                foreach (q[i]) if (q[i].dest == WB_MUX8_out) q[i].vld = 1'b0;
`endif
            if (!gp) begin
                h = q.pop_front();
                if (h.vld) mwait = 0;
            end
            if (MD_valid && e_ready && MD_dest != 0)
                q.push_back('{dest: MD_dest, data: MD_result, vld: 1'b1});
            if (q.size() == 0) mwait = 0;
            m_hold = e_stall;
        end
    end

    task automatic step();
        @(posedge Clock); #2;
    endtask

    task automatic look();
        @(negedge Clock); #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] d, input logic [31:0] x);
        WB_RegWrite = we; WB_MUX8_out = d; WB_Write_data = x;
    endtask

    task automatic md(input logic v, input logic [4:0] d, input logic [31:0] x);
        MD_valid = v; MD_dest = d; MD_result = x;
    endtask

    initial begin
        // A request during reset must not reach the register file.
        wb(1, 8, 32'h11);
        look();
        chk("t0_rst_we", 32'(RF_RegWrite), 0);
        chk("t0_rst_ready", 32'(MD_ready), 0);

        // Plain WB write with MD idle.
        step(); Reset = 0; wb(1, 8, 32'h11); md(0, 0, 0);
        look();
        chk("t1_we", 32'(RF_RegWrite), 1);
        chk("t1_reg", 32'(RF_Write_register), 8);
        chk("t1_data", RF_Write_data, 32'h11);
        chk("t1_stall", 32'(Pipe_stall), 0);
        chk("t1_ready", 32'(MD_ready), 1);

        // MD push with WB idle: written on the following cycle.
        step(); wb(0, 0, 0); md(1, 9, 32'hAA);
        look(); chk("t2_pend0", 32'(MD_pending), 0);
        step(); md(0, 0, 0);
        look();
        chk("t2_we", 32'(RF_RegWrite), 1);
        chk("t2_reg", 32'(RF_Write_register), 9);
        chk("t2_data", RF_Write_data, 32'hAA);
        chk("t2_pend1", 32'(MD_pending), 1);
        step(); look(); chk("t2_pend_end", 32'(MD_pending), 0);

        // Starvation: three WB grants, then a forced MD write with stall.
        step(); wb(1, 1, 32'h101); md(1, 10, 32'h10);
        step(); md(0, 0, 0); wb(1, 2, 32'h102);
        step(); wb(1, 3, 32'h103);
        step(); wb(1, 4, 32'h104);
        look(); chk("t3_reg4", 32'(RF_Write_register), 4);
        chk("t3_nostall", 32'(Pipe_stall), 0);
        step(); wb(1, 5, 32'h105);
        look();
        chk("t3_force_reg", 32'(RF_Write_register), 10);
        chk("t3_force_data", RF_Write_data, 32'h10);
        chk("t3_force_stall", 32'(Pipe_stall), 1);
        step();
        look();
        chk("t3_held_reg", 32'(RF_Write_register), 5);
        chk("t3_held_data", RF_Write_data, 32'h105);
        chk("t3_held_stall", 32'(Pipe_stall), 0);

        // Fill the FIFO, then hold a third MD result until space opens.
        step(); wb(1, 2, 32'h202); md(1, 11, 32'hB1);
        step(); wb(1, 3, 32'h203); md(1, 12, 32'hB2);
        step(); wb(0, 0, 0); md(1, 13, 32'hB3);
        look();
        chk("t4_full_ready", 32'(MD_ready), 0);
        chk("t4_pop1", 32'(RF_Write_register), 11);
        step();
        look();
        chk("t4_pop2", 32'(RF_Write_register), 12);
        chk("t4_ready", 32'(MD_ready), 1);
        step(); md(0, 0, 0);
        look();
        chk("t4_pop3", 32'(RF_Write_register), 13);
        chk("t4_pop3_data", RF_Write_data, 32'hB3);

        // Writes to $0 from either side.
        step(); wb(1, 0, 32'h55); md(1, 0, 32'h66);
        look();
        chk("t5_we", 32'(RF_RegWrite), 0);
        chk("t5_ready", 32'(MD_ready), 1);
        step(); wb(0, 0, 0); md(0, 0, 0);
        look();
        chk("t5_pend", 32'(MD_pending), 0);
        chk("t5_we2", 32'(RF_RegWrite), 0);

        // Random traffic; a stalled WB write is re-presented unchanged.
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!m_hold)
                wb(($urandom_range(0, 99) < ((i < 1500) ? 75 : 30)) ? 1'b1 : 1'b0,
                   5'($urandom_range(0, 7)), $urandom);
            md(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        step(); wb(0, 0, 0); md(0, 0, 0);
        for (int i = 0; i < 4; i++) step();

        // Reset while two results are buffered and a write is being forced.
        step(); wb(1, 2, 32'h302); md(1, 11, 32'hC1);
        step(); wb(1, 3, 32'h303); md(1, 12, 32'hC2);
        step(); wb(1, 4, 32'h304); md(0, 0, 0);
        step(); wb(1, 5, 32'h305);
        step(); wb(1, 6, 32'h306);
        look();
        chk("t6_force_stall", 32'(Pipe_stall), 1);
        chk("t6_force_reg", 32'(RF_Write_register), 11);
        #1 Reset = 1;
        #1;
        chk("t6_rst_we", 32'(RF_RegWrite), 0);
        chk("t6_rst_stall", 32'(Pipe_stall), 0);
        chk("t6_rst_ready", 32'(MD_ready), 0);
        chk("t6_rst_pend", 32'(MD_pending), 0);
        step(); Reset = 0; wb(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            look();
            chk("t6_no_stale_we", 32'(RF_RegWrite), 0);
            chk("t6_ready_after", 32'(MD_ready), 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the pipeline WB stage (driven from MEM_WB) and the multi-cycle multiply/divide unit (MD).
- MD results are held in a small FIFO until the port is free.
- The pipeline WB stage has priority. A starvation counter forces an MD write after a bounded wait, stalling the WB stage for that one cycle.
- Sits between MEM_WB, the MD unit and the register file.

Parameters:
- DEPTH, 2, MD result FIFO entries (power of two, ≥2)
- MAX_WAIT, 3, cycles the FIFO head may be denied before a forced grant (≥1)
- rwidth, 5, register address width
- word, 32, data width

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- WB_RegWrite  input  1  WB stage write request
- WB_MUX8_out  input  rwidth  WB stage destination register
- WB_Write_data  input  word  WB stage data (after MemtoReg mux)
- MD_valid  input  1  MD result offered
- MD_dest  input  rwidth  MD destination register
- MD_result  input  word  MD result data
- MD_ready  output  1  FIFO can accept; MD handshake = MD_valid & MD_ready
- Pipe_stall  output  1  WB stage must hold its registers this cycle
- RF_RegWrite  output  1  register-file write enable
- RF_Write_register  output  rwidth  register-file write address
- RF_Write_data  output  word  register-file write data
- MD_pending  output  1  FIFO non-empty (used by the hazard unit)

Behaviour:
- Reset: asynchronous. Clears FIFO pointers and count, wait counter = 0, state = IDLE.
  - While Reset = 1: RF_RegWrite = 0, Pipe_stall = 0, MD_ready = 0, MD_pending = 0.
  - After reset deassertion: MD_ready = 1.
  - Reset mid-operation discards all buffered results.
- Pipeline request: pipe_req = WB_RegWrite & (WB_MUX8_out != 0). Writes to $0 are never issued.
- Enqueue: on MD_valid & MD_ready at posedge.
  - MD_dest == 0: handshake completes, nothing is stored.
  - MD_ready = !full, computed from registered count only, so it does not depend on same-cycle pop.
  - No bypass: minimum MD-to-RF latency is 1 cycle after the handshake edge.
- States:
  - IDLE (FIFO empty): grant pipe. RF outputs = WB inputs, RF_RegWrite = pipe_req.
  - PEND (FIFO non-empty, wait < MAX_WAIT):
    - If pipe_req: grant pipe, wait += 1.
    - Else: grant FIFO head, pop, wait = 0.
  - FORCE (FIFO non-empty, wait == MAX_WAIT): grant FIFO head, pop, wait = 0. Pipe_stall = pipe_req.
    - With Pipe_stall = 1, the pipeline must present the same WB write next cycle; that write is granted next cycle regardless of FIFO state.
- Transitions, evaluated at posedge on post-update count and wait:
  - count == 0 → IDLE
  - wait == MAX_WAIT → FORCE
  - otherwise → PEND
- All RF outputs and Pipe_stall are combinational from state, FIFO head and WB inputs. No RF write is lost or duplicated.
- Boundaries:
  - Simultaneous push and pop when full: illegal by construction, since MD_ready = 0.
  - Simultaneous push and pop when non-full: count unchanged.
  - Pointers wrap modulo DEPTH.
  - Wait counter saturates at MAX_WAIT.
  - Wait counter clears when the FIFO empties.
- MD_pending = (count != 0).

Optional Feature:
- Macro: RF_WAW_SQUASH_EN
- Defined: when the pipe is granted with pipe_req = 1, every valid FIFO entry whose dest equals WB_MUX8_out is invalidated (the pipeline write is younger).
  - Invalid entries reaching the head are popped with RF_RegWrite = 0.
  - A head popped this way does not reset the wait counter.
- Undefined: no squashing. The hazard unit must guarantee no write-after-write (WAW) overlap.

Test Plan:
- Reset, then WB_RegWrite = 1, dest 8, data 0x11 with MD idle → RF_RegWrite = 1, reg 8, 0x11 same cycle; Pipe_stall = 0, MD_ready = 1.
- MD pushes dest 9 = 0xAA while WB idle → next cycle RF writes reg 9 = 0xAA; MD_pending goes 1 then 0.
- FIFO holds dest 10, continuous WB writes, MAX_WAIT = 3 → three pipe grants, fourth cycle writes reg 10 with Pipe_stall = 1. Next cycle the held WB write is granted.
- Push 2 MD results with WB busy → MD_ready = 0 while full. Third MD_valid held until the first pop, then accepted. Order of writes is FIFO order.
- WB dest 0 and MD dest 0 → RF_RegWrite never 1 for reg 0; the MD handshake completes, count stays 0.
- Reset asserted while 2 entries are buffered and state is FORCE → all outputs at reset values immediately; after release no buffered write appears.
